usb_ep_tx_fifo: RTL and testbench
=================================

// Module: usb_ep_tx_fifo
// PURPOSE
//  Byte FIFO and IN-packet framer between the application byte source and the USB device
//  controller's IN-endpoint interface (txact/txpop/endpt/txcork/txdat/txdat_len).
//  Buffers application bytes and un-corks endpoint EP once a full packet is present or a
//  partial packet has gone stale. It then supplies bytes on txpop strobes.
// PARAMETERS
//  EP         1     endpoint number served; txact/txpop are honoured only when endpt==EP
//  AW         9     FIFO address width; depth = 2**AW bytes
//  MAX_PKT    64    max bytes per IN packet, 1..1024; txdat_len never exceeds it
//  FLUSH_CYC  1000  idle cycles after last write before a partial packet is offered, >=1
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  wr_en      in   1      application write strobe; one byte per cycle
//  wr_dat     in   8      application write byte
//  wr_full    out  1      FIFO full; a write while full is dropped
//  level      out  AW+1   bytes currently stored, 0..2**AW
//  ovf        out  1      sticky; write dropped while full
//  unf        out  1      sticky; txpop ignored (FIFO empty or packet already complete)
//  txact      in   1      controller IN transaction active
//  txpop      in   1      controller consumed txdat this cycle
//  endpt      in   4      endpoint addressed by the controller
//  txval      out  1      txdat holds a byte of the current packet
//  txcork     out  1      1 = NAK, nothing offered; 0 = packet of txdat_len bytes ready
//  txdat      out  8      FIFO head byte; combinational from mem[rd_ptr], 8'h00 when empty
//  txdat_len  out  12     byte count of offered packet, zero-extended
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): rd/wr ptrs=0, level=0, wr_full=0, ovf=unf=0, txcork=1,
//   txval=0, txdat_len=0, idle_cnt=0, sent=0, state=IDLE. Memory is not cleared.
//   The reset applies in any state, including mid-XFER. Unsent data is discarded.
//  Definitions: hit = txact && endpt==EP. pop = hit && txpop && state==XFER && sent<len && level>0.
//  Write accepted when wr_en && !wr_full. wr_full = (level==2**AW), registered with level.
//  Simultaneous accepted write and pop: level unchanged, both pointers advance.
//   Pointers wrap modulo 2**AW.
//  idle_cnt: cleared on any accepted write or when level==0; otherwise increments.
//   Saturates at FLUSH_CYC.
//  FSM:
//   IDLE : txcork=1, txval=0. Go to READY if level>=MAX_PKT, or if level>0 && idle_cnt==FLUSH_CYC.
//          On that edge: txdat_len <= min(level,MAX_PKT).
//   READY: txcork=0. While !hit, txdat_len tracks min(level,MAX_PKT) every cycle.
//          On the first hit cycle: len frozen at current txdat_len, sent<=0, go to XFER.
//   XFER : txcork=0, txdat_len frozen, txval = (sent<len && level>0).
//          Each pop: rd_ptr++, sent++. Next byte appears on txdat the cycle after the pop.
//          txpop on a hit cycle without pop: ignored, unf<=1.
//          Writes continue and do not change len.
//          txact falls (hit=0): next state IDLE, idle_cnt<=0. Unpopped bytes stay queued.
//   Output timing: registered; txcork rises the cycle after txact falls.
//  Non-matching endpt: txact/txpop fully ignored in every state; no flag is set.
//  ovf/unf are cleared only by reset.
// TESTING
//  1 rst_n=0 one cycle from any state -> txcork=1, txval=0, level=0, txdat_len=0, ovf=unf=0.
//  2 write 0x00..0x3F (64 B) -> txcork=0, txdat_len=64. Then txact, endpt=1, 64 pops
//    -> txdat 0x00..0x3F in order, level=0; txcork=1 one cycle after txact drops.
//  3 write 3 B then idle -> txcork stays 1 until exactly FLUSH_CYC cycles after the last write,
//    then txdat_len=3. A 4th write at cycle FLUSH_CYC-1 restarts the count.
//  4 write 513 B with no pops -> level=512, wr_full=1, ovf=1. FIFO contents are the first 512 bytes.
//  5 level=10, write+pop in same cycle -> level stays 10. txact/txpop with endpt=2 -> no pop, unf=0.
//  6 len=64, 5 pops, then a 65th pop after 64 -> unf=1, rd_ptr unchanged.
//    rst_n=0 mid-XFER -> level=0, txcork=1 next cycle.

Source files
------------

// File: rtl/usb_ep_tx_fifo.sv
// usb_ep_tx_fifo: byte FIFO that frames buffered application bytes into USB IN packets,
// un-corking the endpoint once a full packet is queued or a partial one has gone stale.
`timescale 1ns/1ps
module usb_ep_tx_fifo #(
    parameter int EP        = 1,
    parameter int AW        = 9,
    parameter int MAX_PKT   = 64,
    parameter int FLUSH_CYC = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_dat,
    output logic          wr_full,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          unf,
    input  logic          txact,
    input  logic          txpop,
    input  logic [3:0]    endpt,
    output logic          txval,
    output logic          txcork,
    output logic [7:0]    txdat,
    output logic [11:0]   txdat_len
);
    localparam int DEPTH = 1 << AW;
    localparam int IW = $clog2(FLUSH_CYC + 1);
    localparam logic [IW-1:0] FL = IW'(FLUSH_CYC);
    localparam logic [11:0] MP = 12'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, READY, XFER} state_t;

    logic [7:0]    mem [DEPTH];
    state_t        state_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, ovf_q, unf_q, cork_q;
    logic [11:0]   len_q, sent_q, lvl12, avail;
    logic [IW-1:0] idle_q, idle_d;
    logic          hit, pop, wr_acc;

    always_comb begin
        hit     = txact && endpt == 4'(EP);
        wr_acc  = wr_en && !full_q;
        pop     = hit && txpop && state_q == XFER && sent_q < len_q && level_q != '0;
        level_d = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};
        lvl12   = 12'(level_q);
        avail   = lvl12 < MP ? lvl12 : MP;
        idle_d  = (wr_acc || level_q == '0) ? '0 : (idle_q == FL ? idle_q : idle_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            cork_q   <= 1'b1;
            len_q    <= '0;
            sent_q   <= '0;
            idle_q   <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                sent_q   <= sent_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= level_d == (AW+1)'(DEPTH);
            ovf_q   <= ovf_q | (wr_en && full_q);
            unf_q   <= unf_q | (state_q == XFER && hit && txpop && !pop);
            idle_q  <= idle_d;
            case (state_q)
                IDLE: if (lvl12 >= MP || (level_q != '0 && idle_q == FL)) begin
                    state_q <= READY;
                    cork_q  <= 1'b0;
                    len_q   <= avail;
                end
                READY: if (hit) begin
                    state_q <= XFER;
                    sent_q  <= '0;
                end else len_q <= avail;
                XFER: if (!hit) begin
                    // unpopped bytes stay queued; staleness timer restarts
                    state_q <= IDLE;
                    cork_q  <= 1'b1;
                    idle_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_full   = full_q;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign txcork    = cork_q;
    assign txdat_len = len_q;
    assign txval     = state_q == XFER && sent_q < len_q && level_q != '0;
    assign txdat     = level_q == '0 ? 8'h00 : mem[rd_ptr_q];
endmodule

// File: tb/tb_usb_ep_tx_fifo.sv
// tb_usb_ep_tx_fifo: random-data scoreboard bench; a byte queue models FIFO contents and level,
// a negedge monitor compares every consumed txdat against the queue head.
`timescale 1ns/1ps
module tb_usb_ep_tx_fifo;
    localparam int EP = 1, AW = 9, DEPTH = 512, MAX_PKT = 64, FLUSH = 1000;

    logic        clk = 0, rst_n = 0, wr_en = 0, txact = 0, txpop = 0;
    logic [7:0]  wr_dat = 0;
    logic [3:0]  endpt = 0;
    logic        wr_full, ovf, unf, txval, txcork;
    logic [AW:0] level;
    logic [7:0]  txdat;
    logic [11:0] txdat_len;

    usb_ep_tx_fifo #(.EP(EP), .AW(AW), .MAX_PKT(MAX_PKT), .FLUSH_CYC(FLUSH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_dat(wr_dat), .wr_full(wr_full),
        .level(level), .ovf(ovf), .unf(unf), .txact(txact), .txpop(txpop), .endpt(endpt),
        .txval(txval), .txcork(txcork), .txdat(txdat), .txdat_len(txdat_len)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    bit exp_ovf = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_len();
        return exp_q.size() < MAX_PKT ? exp_q.size() : MAX_PKT;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en = 1;
        wr_dat = d;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf = 1;
        cyc();
        wr_en = 0;
    endtask

    task automatic wait_cork0();
        for (int i = 0; i < 3000 && txcork; i++) cyc();
        check("cork_open", 32'(txcork), 0);
    endtask

    task automatic pop_run(input int npop);
        int got = 0;
        for (int i = 0; i < npop + 50 && got < npop; i++) begin
            txpop = txval;
            if (txval) got++;
            cyc();
        end
        txpop = 0;
        check("pop_count", 32'(got), 32'(npop));
    endtask

    task automatic xfer(input int npop);
        txact = 1;
        endpt = 4'(EP);
        cyc();
        pop_run(npop);
        check("cork_in_xfer", 32'(txcork), 0);
        txact = 0;
        cyc();
        check("cork_after_xfer", 32'(txcork), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && txact && endpt == 4'(EP) && txpop && txval) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL txdat: got %0d expected nothing (model empty)", txdat);
            end else check("txdat", 32'(txdat), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        logic [7:0] d;
        cyc();
        cyc();
        check("rst_cork", 32'(txcork), 1);
        check("rst_txval", 32'(txval), 0);
        check("rst_level", 32'(level), 0);
        check("rst_len", 32'(txdat_len), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_unf", 32'(unf), 0);
        check("rst_full", 32'(wr_full), 0);
        rst_n = 1;
        cyc();
        // full packet of 0x00..0x3F
        for (int i = 0; i < 64; i++) wr(8'(i));
        cyc();
        check("pkt_cork", 32'(txcork), 0);
        check("pkt_len", 32'(txdat_len), 32'(exp_len()));
        check("pkt_level", 32'(level), 32'(exp_q.size()));
        xfer(exp_len());
        check("pkt_level_end", 32'(level), 32'(exp_q.size()));
        check("empty_txdat", 32'(txdat), 0);
        // stale partial packet, with a late write restarting the timer
        for (int i = 0; i < 3; i++) wr(8'($urandom));
        repeat (FLUSH - 2) cyc();
        check("stale_pre4", 32'(txcork), 1);
        wr(8'($urandom));
        repeat (FLUSH) cyc();
        check("stale_at_flush", 32'(txcork), 1);
        cyc();
        check("stale_open", 32'(txcork), 0);
        check("stale_len", 32'(txdat_len), 32'(exp_len()));
        xfer(exp_len());
        check("stale_level", 32'(level), 32'(exp_q.size()));
        // overflow
        repeat (DEPTH + 1) wr(8'($urandom));
        cyc();
        check("ovf_level", 32'(level), 32'(exp_q.size()));
        check("ovf_full", 32'(wr_full), 32'(exp_q.size() == DEPTH));
        check("ovf_flag", 32'(ovf), 32'(exp_ovf));
        for (int p = 0; p < DEPTH / MAX_PKT; p++) begin
            wait_cork0();
            e = exp_len();
            check("drain_len", 32'(txdat_len), 32'(e));
            xfer(e);
        end
        check("drain_level", 32'(level), 32'(exp_q.size()));
        check("drain_full", 32'(wr_full), 0);
        // foreign endpoint, concurrent write+pop, over-pop
        for (int i = 0; i < 10; i++) wr(8'($urandom));
        wait_cork0();
        check("ten_len", 32'(txdat_len), 32'(exp_len()));
        e = exp_len();
        txact = 1;
        endpt = 2;
        txpop = 1;
        repeat (3) cyc();
        check("foreign_level", 32'(level), 32'(exp_q.size()));
        check("foreign_unf", 32'(unf), 0);
        check("foreign_cork", 32'(txcork), 0);
        txpop = 0;
        endpt = 4'(EP);
        cyc();
        d = 8'($urandom);
        wr_en = 1;
        wr_dat = d;
        exp_q.push_back(d);
        txpop = txval;
        cyc();
        wr_en = 0;
        txpop = 0;
        check("wrpop_level", 32'(level), 32'(exp_q.size()));
        pop_run(e - 1);
        check("txval_done", 32'(txval), 0);
        txpop = 1;
        cyc();
        txpop = 0;
        check("overpop_unf", 32'(unf), 1);
        check("overpop_level", 32'(level), 32'(exp_q.size()));
        txact = 0;
        cyc();
        check("overpop_cork", 32'(txcork), 1);
        // reset in the middle of a transfer
        for (int i = 0; i < 70; i++) wr(8'($urandom));
        wait_cork0();
        check("mid_len", 32'(txdat_len), 32'(exp_len()));
        txact = 1;
        cyc();
        pop_run(5);
        check("mid_level", 32'(level), 32'(exp_q.size()));
        rst_n = 0;
        cyc();
        rst_n = 1;
        txact = 0;
        exp_q.delete();
        exp_ovf = 0;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_cork", 32'(txcork), 1);
        check("mid_rst_txval", 32'(txval), 0);
        check("mid_rst_len", 32'(txdat_len), 0);
        check("mid_rst_unf", 32'(unf), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
